// File: rtl/rs_issue_tracker.sv
// Reservation-station occupancy/issue tracker; RS_ISSUE_RR_EN selects rotating-priority issue.
// Latency: ready write or wakeup at T -> issue_valid at T+2; busy/free_cnt update at T+1.
// Backpressure: issue_valid/issue_ent hold while issue_ack is low; the presented entry stays busy.
module rs_issue_tracker #(
    parameter int REQ_LEN   = 4,
    parameter int GRANT_LEN = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we1,
    input  logic [GRANT_LEN-1:0] waddr1,
    input  logic                 wready1,
    input  logic                 we2,
    input  logic [GRANT_LEN-1:0] waddr2,
    input  logic                 wready2,
    input  logic [REQ_LEN-1:0]   ready_set,
    input  logic                 kill,
    input  logic                 issue_ack,
    output logic                 issue_valid,
    output logic [GRANT_LEN-1:0] issue_ent,
    output logic [REQ_LEN-1:0]   busy,
    output logic [GRANT_LEN:0]   free_cnt
);

    logic [REQ_LEN-1:0]   ready_r;
    logic                 release_vld;
    logic                 issue_load;
    logic [REQ_LEN-1:0]   rel_mask;
    logic [REQ_LEN-1:0]   wr1_mask;
    logic [REQ_LEN-1:0]   wr2_mask;
    logic [REQ_LEN-1:0]   busy_nxt;
    logic [REQ_LEN-1:0]   ready_nxt;
    logic [REQ_LEN-1:0]   cand;
    logic [GRANT_LEN:0]   free_nxt;
    logic                 sel_vld;
    logic [GRANT_LEN-1:0] sel_idx;

    assign release_vld = issue_valid & issue_ack;
    assign issue_load  = !issue_valid | issue_ack;

    always_comb begin
        rel_mask = '0;
        wr1_mask = '0;
        wr2_mask = '0;
        for (int i = 0; i < REQ_LEN; i++) begin
            rel_mask[i] = release_vld && (issue_ent == GRANT_LEN'(i));
            wr1_mask[i] = we1 && (waddr1 == GRANT_LEN'(i));
            wr2_mask[i] = we2 && (waddr2 == GRANT_LEN'(i));
        end
    end

    // Writes beat release and wakeup for the same entry; wakeup only lands on busy entries.
    always_comb begin
        busy_nxt  = (busy & ~rel_mask) | wr1_mask | wr2_mask;
        ready_nxt = '0;
        for (int i = 0; i < REQ_LEN; i++) begin
            ready_nxt[i] = (ready_r[i] | (ready_set[i] & busy[i])) & ~rel_mask[i];
            if (wr1_mask[i]) begin
                ready_nxt[i] = wready1;
            end else if (wr2_mask[i]) begin
                ready_nxt[i] = wready2;
            end
        end
    end

    always_comb begin
        free_nxt = '0;
        for (int i = 0; i < REQ_LEN; i++) begin
            if (!busy_nxt[i]) begin
                free_nxt = free_nxt + (GRANT_LEN+1)'(1);
            end
        end
    end

    // The entry leaving this cycle must not be picked again.
    assign cand    = busy & ready_r & ~rel_mask;
    assign sel_vld = |cand;

`ifdef RS_ISSUE_RR_EN
    logic [GRANT_LEN-1:0] rr_ptr;
    logic [GRANT_LEN-1:0] rr_ptr_nxt;

    always_comb begin
        logic found;
        found   = 1'b0;
        sel_idx = issue_ent;
        for (int k = 0; k < REQ_LEN; k++) begin
            if (!found && cand[(int'(rr_ptr) + k) % REQ_LEN]) begin
                found   = 1'b1;
                sel_idx = GRANT_LEN'((int'(rr_ptr) + k) % REQ_LEN);
            end
        end
    end

    always_comb begin
        if (int'(sel_idx) + 1 >= REQ_LEN) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = sel_idx + GRANT_LEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || kill) begin
            rr_ptr <= '0;
        end else if (issue_load && sel_vld) begin
            rr_ptr <= rr_ptr_nxt;
        end
    end
`else
    always_comb begin
        sel_idx = issue_ent;
        for (int i = REQ_LEN - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_idx = GRANT_LEN'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy        <= '0;
            ready_r     <= '0;
            issue_valid <= 1'b0;
            issue_ent   <= '0;
            free_cnt    <= (GRANT_LEN+1)'(REQ_LEN);
        end else if (kill) begin
            busy        <= '0;
            ready_r     <= '0;
            issue_valid <= 1'b0;
            free_cnt    <= (GRANT_LEN+1)'(REQ_LEN);
        end else begin
            busy     <= busy_nxt;
            ready_r  <= ready_nxt;
            free_cnt <= free_nxt;
            if (issue_load) begin
                issue_valid <= sel_vld;
                issue_ent   <= sel_idx;
            end
        end
    end

    // Allocator contract checks; hardware takes no corrective action.
    always_ff @(posedge clk) begin
        if (reset && !kill) begin
            assert (!(we1 && we2 && (waddr1 == waddr2)));
            assert ((wr1_mask & busy & ~rel_mask) == '0);
            assert ((wr2_mask & busy & ~rel_mask) == '0);
            assert (!we1 || ({1'b0, waddr1} < (GRANT_LEN+1)'(REQ_LEN)));
            assert (!we2 || ({1'b0, waddr2} < (GRANT_LEN+1)'(REQ_LEN)));
            assert (!(issue_ack && !issue_valid));
        end
    end

endmodule

// File: tb/tb_rs_issue_tracker.sv
// Directed bench for rs_issue_tracker (REQ_LEN=4): occupancy, wakeup, issue handshake, kill, reset.
module tb_rs_issue_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       we1, wready1, we2, wready2;
    logic [1:0] waddr1, waddr2;
    logic [3:0] ready_set;
    logic       kill, issue_ack;
    logic       issue_valid;
    logic [1:0] issue_ent;
    logic [3:0] busy;
    logic [2:0] free_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_seq[4];

    rs_issue_tracker #(.REQ_LEN(4), .GRANT_LEN(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .we1        (we1),
        .waddr1     (waddr1),
        .wready1    (wready1),
        .we2        (we2),
        .waddr2     (waddr2),
        .wready2    (wready2),
        .ready_set  (ready_set),
        .kill       (kill),
        .issue_ack  (issue_ack),
        .issue_valid(issue_valid),
        .issue_ent  (issue_ent),
        .busy       (busy),
        .free_cnt   (free_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        we1 = 1'b0; waddr1 = 2'd0; wready1 = 1'b0;
        we2 = 1'b0; waddr2 = 2'd0; wready2 = 1'b0;
        ready_set = 4'b0000; kill = 1'b0; issue_ack = 1'b0;
    endtask

    initial begin
`ifdef RS_ISSUE_RR_EN
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0;
`else
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 3;
`endif
        clear_inputs();
        reset = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_free", 32'(free_cnt), 4);
        check("rst_valid", 32'(issue_valid), 0);
        check("rst_ent", 32'(issue_ent), 0);
        reset = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 0);
        check("idle_free", 32'(free_cnt), 4);
        check("idle_valid", 32'(issue_valid), 0);

        // Dual write: entry 2 ready, entry 0 not ready
        we1 = 1'b1; waddr1 = 2'd2; wready1 = 1'b1;
        we2 = 1'b1; waddr2 = 2'd0; wready2 = 1'b0;
        tick();
        check("wr_busy", 32'(busy), 32'h5);
        check("wr_free", 32'(free_cnt), 2);
        check("wr_valid_t1", 32'(issue_valid), 0);
        clear_inputs();
        tick();
        check("wr_valid_t2", 32'(issue_valid), 1);
        check("wr_ent_t2", 32'(issue_ent), 2);
        issue_ack = 1'b1;
        tick();
        issue_ack = 1'b0;
        check("ack_busy", 32'(busy), 32'h1);
        check("ack_free", 32'(free_cnt), 3);
        check("ack_valid", 32'(issue_valid), 0);

        // Wakeup of entry 0, then hold without ack
        ready_set = 4'b0001;
        tick();
        ready_set = 4'b0000;
        check("wake_valid_t1", 32'(issue_valid), 0);
        tick();
        check("wake_valid_t2", 32'(issue_valid), 1);
        check("wake_ent_t2", 32'(issue_ent), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_valid", 32'(issue_valid), 1);
            check("hold_ent", 32'(issue_ent), 0);
            check("hold_busy0", 32'(busy[0]), 1);
        end
        issue_ack = 1'b1;
        tick();
        issue_ack = 1'b0;
        check("wake_rel_busy", 32'(busy), 0);
        check("wake_rel_free", 32'(free_cnt), 4);
        check("wake_rel_valid", 32'(issue_valid), 0);

        // All four ready, ack every cycle
        we1 = 1'b1; waddr1 = 2'd0; wready1 = 1'b1;
        we2 = 1'b1; waddr2 = 2'd1; wready2 = 1'b1;
        tick();
        waddr1 = 2'd2; waddr2 = 2'd3;
        tick();
        clear_inputs();
        check("fill_busy", 32'(busy), 32'hf);
        check("fill_free", 32'(free_cnt), 0);
        for (int k = 0; k < 4; k++) begin
            check("seq_valid", 32'(issue_valid), 1);
            check("seq_ent", 32'(issue_ent), 32'(exp_seq[k]));
            issue_ack = 1'b1;
            tick();
        end
        issue_ack = 1'b0;
        check("seq_end_valid", 32'(issue_valid), 0);
        check("seq_end_busy", 32'(busy), 0);
        check("seq_end_free", 32'(free_cnt), 4);

        // Release and rewrite of entry 1 in the same cycle
        we1 = 1'b1; waddr1 = 2'd1; wready1 = 1'b1;
        tick();
        clear_inputs();
        tick();
        check("rw_valid", 32'(issue_valid), 1);
        check("rw_ent", 32'(issue_ent), 1);
        issue_ack = 1'b1; we1 = 1'b1; waddr1 = 2'd1; wready1 = 1'b0;
        tick();
        clear_inputs();
        check("rw_busy", 32'(busy), 32'h2);
        check("rw_free", 32'(free_cnt), 3);
        check("rw_valid_t1", 32'(issue_valid), 0);
        tick(); tick();
        check("rw_no_reissue", 32'(issue_valid), 0);
        ready_set = 4'b0010;
        tick();
        ready_set = 4'b0000;
        tick();
        check("rw_wake_valid", 32'(issue_valid), 1);
        check("rw_wake_ent", 32'(issue_ent), 1);

        // Kill with full occupancy and a presented entry
        we1 = 1'b1; waddr1 = 2'd0; wready1 = 1'b0;
        we2 = 1'b1; waddr2 = 2'd2; wready2 = 1'b0;
        tick();
        clear_inputs();
        we1 = 1'b1; waddr1 = 2'd3; wready1 = 1'b0;
        tick();
        clear_inputs();
        check("pre_kill_busy", 32'(busy), 32'hf);
        check("pre_kill_valid", 32'(issue_valid), 1);
        kill = 1'b1; issue_ack = 1'b1; we1 = 1'b1; waddr1 = 2'd0; wready1 = 1'b1;
        tick();
        clear_inputs();
        check("kill_busy", 32'(busy), 0);
        check("kill_free", 32'(free_cnt), 4);
        check("kill_valid", 32'(issue_valid), 0);
        tick();
        check("post_kill_busy", 32'(busy), 0);
        check("post_kill_valid", 32'(issue_valid), 0);

        // Reset mid-handshake overrides ack and write
        we1 = 1'b1; waddr1 = 2'd3; wready1 = 1'b1;
        tick();
        clear_inputs();
        tick();
        check("pre_rst_valid", 32'(issue_valid), 1);
        check("pre_rst_ent", 32'(issue_ent), 3);
        reset = 1'b0; issue_ack = 1'b1; we1 = 1'b1; waddr1 = 2'd1; wready1 = 1'b1;
        tick();
        clear_inputs();
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(issue_valid), 0);
        check("mid_rst_ent", 32'(issue_ent), 0);
        check("mid_rst_free", 32'(free_cnt), 4);
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_issue_tracker.md
Name: rs_issue_tracker

Overview:
- Occupancy and issue side of a reservation station; the allocator fills entries, this block tracks them and hands them out.
- Holds per-entry busy/ready state and accepts up to two entry writes per cycle from the allocator.
- Wakes entries from a ready-set vector, selects one ready entry per cycle, and presents it on a valid/ack issue handshake.
- Frees the entry on ack. Exports the busy vector back to the allocator and a free-entry count to dispatch stall logic.

Parameters:
- REQ_LEN, 4, number of reservation-station entries.
- GRANT_LEN, 2, entry index width; REQ_LEN <= 2**GRANT_LEN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- we1  in  1  write entry waddr1 this cycle.
- waddr1  in  GRANT_LEN  entry index for write 1.
- wready1  in  1  operands of write 1 already ready.
- we2  in  1  write entry waddr2 this cycle.
- waddr2  in  GRANT_LEN  entry index for write 2.
- wready2  in  1  operands of write 2 already ready.
- ready_set  in  REQ_LEN  wakeup, one bit per entry.
- kill  in  1  flush; invalidates all entries.
- issue_ack  in  1  consumer accepts the presented entry.
- issue_valid  out  1  an entry is presented.
- issue_ent  out  GRANT_LEN  presented entry index.
- busy  out  REQ_LEN  registered occupancy vector, to allocator.
- free_cnt  out  GRANT_LEN+1  number of zero bits in busy, registered.

Behaviour:
- Reset (reset==0 at posedge): busy=0, ready=0, issue_valid=0, issue_ent=0, free_cnt=REQ_LEN. Reset overrides all inputs, including mid-handshake.
- State registers: busy[i], ready[i], issue_valid, issue_ent, free_cnt. All outputs are registered.
- Per-cycle update, highest priority first:
  1. kill: busy=0, ready=0, issue_valid=0, free_cnt=REQ_LEN. Same-cycle we1/we2/issue_ack are ignored.
  2. Release: if issue_valid & issue_ack, clear busy[issue_ent] and ready[issue_ent].
  3. Writes: we1 sets busy[waddr1] and sets ready[waddr1]=wready1; likewise for we2. A write to the entry released in the same cycle wins, so the entry ends busy with the new ready value.
  4. Wakeup: ready[i] |= ready_set[i] & busy_now[i], where busy_now is the pre-update value. ready_set on a non-busy entry is ignored. A write in the same cycle overrides wakeup for that entry.
- Candidate vector: cand = busy & ready on current registers. When releasing this cycle, also mask off issue_ent.
- Issue register:
  - Loads only when (!issue_valid) | issue_ack.
  - On load: issue_valid = |cand; issue_ent = the selected index (lowest set bit of cand), or unchanged when cand==0.
  - While issue_valid & !issue_ack: issue_valid and issue_ent hold stable, and the entry stays busy.
- Latency:
  - Write with wready=1 at cycle T -> issue_valid at T+2.
  - Wakeup at T on a busy entry -> issue_valid at T+2, if the issue register is free.
  - Back-to-back issue with ack every cycle gives one entry per cycle.
- free_cnt: popcount of ~next_busy, registered alongside busy. Width GRANT_LEN+1 so REQ_LEN=4 gives 3'd4.
- Illegal stimulus (simulation assertions only, no recovery logic):
  - we1 & we2 & waddr1==waddr2.
  - A write to an entry already busy and not being released.
  - waddr >= REQ_LEN.
  - issue_ack while !issue_valid; this is ignored in hardware.

Optional Feature:
- Macro: RS_ISSUE_RR_EN.
- Defined: a GRANT_LEN-bit rotate pointer, reset 0. Selection picks the first set bit of cand searching upward from the pointer with wrap-around. On each load with issue_valid=1, the pointer becomes issue_ent+1 mod REQ_LEN. kill resets the pointer to 0.
- Not defined: fixed lowest-index-first selection and no pointer register.

Test Plan (REQ_LEN=4):
- Reset, then idle -> busy=4'b0000, free_cnt=4, issue_valid=0.
- we1 to entry 2 with wready1=1, and we2 to entry 0 with wready2=0, at T -> busy=4'b0101 and free_cnt=2 at T+1; issue_valid=1 with issue_ent=2 at T+2. Ack at T+2 -> busy=4'b0001 and free_cnt=3 at T+3.
- Entry 0 busy and not ready; ready_set=4'b0001 at T -> issue_ent=0 at T+2. Hold issue_ack=0 for 3 cycles -> issue_valid and issue_ent stable, busy[0]=1.
- Entries 0..3 all ready, ack every cycle -> issue_ent sequence 0,1,2,3 on consecutive cycles, free_cnt ends at 4. With RS_ISSUE_RR_EN and pointer starting at 2 -> sequence 2,3,0,1.
- Ack of entry 1 and we1 to entry 1 (wready1=0) in the same cycle -> busy[1]=1, ready[1]=0, and entry 1 is not reissued.
- kill while issue_valid=1 with busy=4'b1111 -> next cycle busy=0, free_cnt=4, issue_valid=0. A simultaneous issue_ack and we1 have no effect.
